boardman_tx_arbiter: RTL and testbench

//  Shares the single UART TX byte stream between two packet sources: the boardman

---
 rtl/boardman_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_boardman_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boardman_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX byte stream between the boardman
// response path (s0) and the async event/log path (s1), with a mid-packet stall watchdog.
module boardman_tx_arbiter #(
  parameter int STALL_TIMEOUT = 100000,
  parameter int CNT_BITS      = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_axis_tdata,
  input  logic       s0_axis_tvalid,
  input  logic       s0_axis_tlast,
  output logic       s0_axis_tready,
  input  logic [7:0] s1_axis_tdata,
  input  logic       s1_axis_tvalid,
  input  logic       s1_axis_tlast,
  output logic       s1_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [1:0] grant,
  output logic       abort_pulse,
  output logic       abort_src
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PASS0 = 2'b01,
    PASS1 = 2'b10
  } state_t;

  localparam logic                STALL_EN    = (STALL_TIMEOUT > 0);
  localparam logic [CNT_BITS-1:0] STALL_LIMIT = STALL_EN ? CNT_BITS'(STALL_TIMEOUT - 1)
                                                         : {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_MAX     = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_ONE     = {{(CNT_BITS-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              next_state;
  logic                last_served;
  logic                next_last_served;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] next_stall_cnt;
  logic                next_abort_pulse;
  logic                next_abort_src;

  logic                sel_src;
  logic                sel_valid;
  logic                sel_last;

  // Owner view: which source the current PASS state is forwarding.
  always_comb begin
    sel_src   = (state == PASS1);
    sel_valid = sel_src ? s1_axis_tvalid : s0_axis_tvalid;
    sel_last  = sel_src ? s1_axis_tlast  : s0_axis_tlast;
  end

  // Zero-latency pass-through of the granted source; everything idles otherwise.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = 8'h00;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      PASS0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tvalid ? s0_axis_tdata : 8'h00;
        s0_axis_tready = m_axis_tready;
      end
      PASS1: begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tvalid ? s1_axis_tdata : 8'h00;
        s1_axis_tready = m_axis_tready;
      end
      default: begin
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = 8'h00;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
      end
    endcase
  end

  assign grant = {state == PASS1, state == PASS0};

  // Arbitration, packet-end detection and stall watchdog.
  always_comb begin
    next_state       = state;
    next_last_served = last_served;
    next_stall_cnt   = stall_cnt;
    next_abort_pulse = 1'b0;
    next_abort_src   = abort_src;
    case (state)
      IDLE: begin
        next_stall_cnt = {CNT_BITS{1'b0}};
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          next_state = last_served ? PASS0 : PASS1;
        end else if (s0_axis_tvalid) begin
          next_state = PASS0;
        end else if (s1_axis_tvalid) begin
          next_state = PASS1;
        end else begin
          next_state = IDLE;
        end
      end
      PASS0, PASS1: begin
        if (sel_valid) begin
          // Backpressure holds valid high, so it never feeds the watchdog.
          next_stall_cnt = {CNT_BITS{1'b0}};
          if (m_axis_tready && sel_last) begin
            next_state       = IDLE;
            next_last_served = sel_src;
          end else begin
            next_state = state;
          end
        end else if (STALL_EN && (stall_cnt == STALL_LIMIT)) begin
          next_state       = IDLE;
          next_stall_cnt   = {CNT_BITS{1'b0}};
          next_abort_pulse = 1'b1;
          next_abort_src   = sel_src;
          next_last_served = sel_src;
        end else begin
          next_stall_cnt = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CNT_ONE;
        end
      end
      default: begin
        next_state     = IDLE;
        next_stall_cnt = {CNT_BITS{1'b0}};
      end
    endcase
  end

  // State register; s0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      stall_cnt   <= {CNT_BITS{1'b0}};
      abort_pulse <= 1'b0;
      abort_src   <= 1'b0;
    end else begin
      state       <= next_state;
      last_served <= next_last_served;
      stall_cnt   <= next_stall_cnt;
      abort_pulse <= next_abort_pulse;
      abort_src   <= next_abort_src;
    end
  end

endmodule

// File: tb/tb_boardman_tx_arbiter.sv
// Directed vector table plus hand-written stall, backpressure, reset and random
// scoreboard sequences for boardman_tx_arbiter.
module tb_boardman_tx_arbiter;

  localparam int TO  = 16;
  localparam int NPK = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s0_tdata, s1_tdata, m_tdata;
  logic       s0_tvalid, s0_tlast, s0_tready;
  logic       s1_tvalid, s1_tlast, s1_tready;
  logic       m_tvalid, m_tready;
  logic [1:0] grant;
  logic       abort_pulse, abort_src;

  boardman_tx_arbiter #(.STALL_TIMEOUT(TO), .CNT_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tlast(s0_tlast),
    .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tlast(s1_tlast),
    .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant(grant), .abort_pulse(abort_pulse), .abort_src(abort_src)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       v0; logic [7:0] d0; logic l0;
    logic       v1; logic [7:0] d1; logic l1;
    logic       rdy;
    logic [1:0] g;  logic mv; logic [7:0] md; logic r0; logic r1;
  } vec_t;

  vec_t vt[25];

  // random-phase state
  logic       sv[2];
  logic [7:0] sd[2];
  logic       sl[2];
  logic       hs[2];
  int         left[2], seq[2], started[2], gapc[2], mseq[2], done[2];
  int         pkt_owner, last_done, own, cyc, bad;
  logic       arb_pend;
  logic [1:0] arb_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1, input logic rdy);
    s0_tvalid = v0; s0_tdata = d0; s0_tlast = l0;
    s1_tvalid = v1; s1_tdata = d1; s1_tlast = l1;
    m_tready  = rdy;
  endtask

  function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic l0,
                              input logic v1, input logic [7:0] d1, input logic l1,
                              input logic rdy, input logic [1:0] g, input logic mv,
                              input logic [7:0] md, input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.rdy = rdy;
    v.g = g; v.mv = mv; v.md = md; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic stall_abort(input logic src);
    logic early;
    early = 1'b0;
    if (src) drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
    else     drive(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    settle();
    step();
    settle();
    chk($sformatf("stall%0d grant", src), grant, src ? 2'b10 : 2'b01);
    step();
    // last tvalid=1 cycle has been sampled; source goes quiet, s1 pends behind an s0 stall
    if (src) drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    else     drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
    for (int k = 1; k <= TO; k++) begin
      step();
      settle();
      if (k < TO - 1) early = early | abort_pulse;
      if (k == TO - 1) begin
        chk($sformatf("stall%0d no abort at %0d", src, k), abort_pulse, 1'b0);
        chk($sformatf("stall%0d still granted", src), grant, src ? 2'b10 : 2'b01);
      end
      if (k == TO) begin
        chk($sformatf("stall%0d abort_pulse", src), abort_pulse, 1'b1);
        chk($sformatf("stall%0d abort_src", src), abort_src, src);
        chk($sformatf("stall%0d grant idle", src), grant, 2'b00);
      end
    end
    chk($sformatf("stall%0d early abort", src), early, 1'b0);
    step();
    settle();
    chk($sformatf("stall%0d pulse one cycle", src), abort_pulse, 1'b0);
    if (!src) begin
      chk("stall0 s1 served", grant, 2'b10);
      chk("stall0 s1 byte", m_tdata, 8'h66);
      step();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      settle();
      chk("stall0 s1 done", grant, 2'b00);
    end else begin
      chk("stall1 grant idle", grant, 2'b00);
    end
    step();
  endtask

  initial begin
    vt[0]  = mk(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[1]  = mk(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b1, 1'b0);
    vt[2]  = mk(1'b1, 8'hA2, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 2'b01, 1'b1, 8'hA2, 1'b1, 1'b0);
    vt[3]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[4]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 2'b10, 1'b1, 8'hB1, 1'b0, 1'b1);
    vt[5]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 2'b10, 1'b1, 8'hB2, 1'b0, 1'b1);
    vt[6]  = mk(1'b1, 8'hA3, 1'b0, 1'b1, 8'hB3, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[7]  = mk(1'b1, 8'hA3, 1'b1, 1'b1, 8'hB3, 1'b0, 1'b1, 2'b01, 1'b1, 8'hA3, 1'b1, 1'b0);
    vt[8]  = mk(1'b1, 8'hA4, 1'b0, 1'b1, 8'hB3, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[9]  = mk(1'b1, 8'hA4, 1'b0, 1'b1, 8'hB3, 1'b0, 1'b0, 2'b10, 1'b1, 8'hB3, 1'b0, 1'b0);
    vt[10] = mk(1'b1, 8'hA4, 1'b0, 1'b1, 8'hB3, 1'b1, 1'b1, 2'b10, 1'b1, 8'hB3, 1'b0, 1'b1);
    vt[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[12] = mk(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[13] = mk(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 8'h11, 1'b1, 1'b0);
    vt[14] = mk(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 8'h22, 1'b1, 1'b0);
    vt[15] = mk(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 8'h33, 1'b1, 1'b0);
    vt[16] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[18] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 2'b10, 1'b1, 8'hC1, 1'b0, 1'b1);
    vt[19] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hC2, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[20] = mk(1'b1, 8'hD1, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b1, 2'b10, 1'b1, 8'hC2, 1'b0, 1'b1);
    vt[21] = mk(1'b1, 8'hD1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    vt[22] = mk(1'b0, 8'hD1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
    vt[23] = mk(1'b1, 8'hD1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b1, 8'hD1, 1'b1, 1'b0);
    vt[24] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);

    // reset state, with a source and the sink both asking to move data
    rst = 1'b1;
    drive(1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1);
    step();
    step();
    settle();
    chk("rst grant", grant, 2'b00);
    chk("rst m_tvalid", m_tvalid, 1'b0);
    chk("rst s0_tready", s0_tready, 1'b0);
    chk("rst s1_tready", s1_tready, 1'b0);
    chk("rst abort_pulse", abort_pulse, 1'b0);
    chk("rst abort_src", abort_src, 1'b0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(vt[i].v0, vt[i].d0, vt[i].l0, vt[i].v1, vt[i].d1, vt[i].l1, vt[i].rdy);
      settle();
      chk($sformatf("vec%0d grant", i), grant, vt[i].g);
      chk($sformatf("vec%0d m_tvalid", i), m_tvalid, vt[i].mv);
      chk($sformatf("vec%0d m_tdata", i), m_tdata, vt[i].md);
      chk($sformatf("vec%0d s0_tready", i), s0_tready, vt[i].r0);
      chk($sformatf("vec%0d s1_tready", i), s1_tready, vt[i].r1);
      chk($sformatf("vec%0d abort_pulse", i), abort_pulse, 1'b0);
      step();
    end

    // long downstream backpressure on s1 must never trip the watchdog
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h71, 1'b0, 1'b0);
    settle();
    step();
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      settle();
      if (abort_pulse || grant != 2'b10 || s1_tready || !m_tvalid) bad++;
      step();
    end
    chk("bp hold bad cycles", bad, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h71, 1'b0, 1'b1);
    settle();
    chk("bp byte0", m_tdata, 8'h71);
    chk("bp s1_tready", s1_tready, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h72, 1'b0, 1'b1);
    settle();
    chk("bp byte1", m_tdata, 8'h72);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h73, 1'b1, 1'b1);
    settle();
    chk("bp byte2", m_tdata, 8'h73);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    settle();
    chk("bp idle after", grant, 2'b00);
    step();

    stall_abort(1'b0);
    stall_abort(1'b1);

    // asynchronous reset in the middle of an s1 packet with s0 pending
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1);
    settle();
    step();
    drive(1'b1, 8'h91, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1);
    settle();
    chk("arst pre grant", grant, 2'b10);
    step();
    drive(1'b1, 8'h91, 1'b1, 1'b1, 8'h82, 1'b0, 1'b1);
    settle();
    rst = 1'b1;
    #1;
    chk("arst grant", grant, 2'b00);
    chk("arst m_tvalid", m_tvalid, 1'b0);
    chk("arst s0_tready", s0_tready, 1'b0);
    chk("arst s1_tready", s1_tready, 1'b0);
    step();
    step();
    rst = 1'b0;
    settle();
    chk("arst idle after release", grant, 2'b00);
    step();
    settle();
    chk("arst s0 first", grant, 2'b01);
    chk("arst s0 byte", m_tdata, 8'h91);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step();

    // random traffic scoreboard from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sd[i] = 8'h00; sl[i] = 1'b0; hs[i] = 1'b0;
      left[i] = 0; seq[i] = 0; started[i] = 0; gapc[i] = 0; mseq[i] = 0; done[i] = 0;
    end
    pkt_owner = -1;
    last_done = 1;
    arb_pend  = 1'b0;
    arb_exp   = 2'b00;
    cyc       = 0;
    while ((done[0] < NPK || done[1] < NPK) && cyc < 40000) begin
      for (int i = 0; i < 2; i++) begin
        if (!sv[i] && (gapc[i] >= 3 || $urandom_range(0, 3) != 0)) begin
          if (left[i] == 0 && started[i] < NPK) begin
            left[i] = $urandom_range(1, 4);
            started[i]++;
          end
          if (left[i] > 0) begin
            sv[i] = 1'b1;
            sd[i] = {i[0], seq[i][6:0]};
            sl[i] = (left[i] == 1);
          end
          gapc[i] = 0;
        end else if (!sv[i]) begin
          gapc[i]++;
        end
      end
      drive(sv[0], sd[0], sl[0], sv[1], sd[1], sl[1], ($urandom_range(0, 3) != 0));
      settle();
      if (arb_pend) chk("rand arbitration", grant, arb_exp);
      arb_pend = 1'b0;
      if (abort_pulse) chk("rand abort", abort_pulse, 1'b0);
      if (grant == 2'b00 && (sv[0] || sv[1])) begin
        arb_pend = 1'b1;
        if (sv[0] && sv[1]) arb_exp = (last_done == 1) ? 2'b01 : 2'b10;
        else                arb_exp = sv[0] ? 2'b01 : 2'b10;
      end
      if (m_tvalid && m_tready) begin
        chk("rand xfer grant", (grant == 2'b01 || grant == 2'b10), 1'b1);
        own = grant[1] ? 1 : 0;
        if (pkt_owner >= 0 && pkt_owner != own) chk("rand unmixed", own, pkt_owner);
        chk("rand byte", m_tdata, {own[0], mseq[own][6:0]});
        mseq[own]++;
        pkt_owner = own;
        if (sl[own]) begin
          pkt_owner = -1;
          last_done = own;
          done[own]++;
        end
      end
      hs[0] = sv[0] && s0_tready;
      hs[1] = sv[1] && s1_tready;
      step();
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          sv[i] = 1'b0;
          seq[i]++;
          left[i]--;
        end
      end
      cyc++;
    end
    chk("rand all packets delivered", (done[0] >= NPK && done[1] >= NPK), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
